// File: rtl/result_tx_pkg.sv
// result_tx_pkg
// Shared types and constants for the result readout UART.
//   tx_state_t  : readout FSM states
//   DATA_BITS   : payload bits per UART frame
//   FRAME_BITS  : start + data + stop bits per frame
package result_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    DATA,
    STOP,
    CSUM,
    DONE
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
// Free-running bit-period counter for the UART transmitter.
//   clock   : system clock
//   reset   : synchronous active-high reset
//   restart : hold the counter at zero (used outside the timed states)
//   bit_end : one-cycle pulse in the last clock of each bit period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_reg;

  assign bit_end = (cnt_reg == CW'(CLKS_PER_BIT - 1));

  // Wrapping to zero on bit_end makes back-to-back bits line up exactly
  // with no extra cycle between them.
  always_ff @(posedge clock) begin
    if (reset || restart || bit_end) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx
// Dumps LEN result bytes starting at BASE_ADDR out of data memory as 8N1
// UART frames once the CPU signals completion (rising edge of finished).
//   clock, reset : system clock, synchronous active-high reset
//   finished     : CPU run-complete level; its rising edge starts a dump
//   mem_addr     : data-memory read address (BASE_ADDR + byte counter)
//   mem_rd       : read strobe, data returns on mem_data one cycle later
//   mem_data     : synchronous memory read data
//   tx           : UART line, idle high
//   busy         : dump in progress
//   done         : dump complete, held until finished falls
// Optional feature: define RESULT_TX_CHECKSUM_EN to append one extra frame
// carrying the XOR of all bytes sent in the dump.
module result_uart_tx
  import result_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter logic [15:0] LEN          = 16'd256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        finished,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  tx_state_t   state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  bit_reg, bit_next;
  logic        finished_reg;
  logic        trigger;
  logic        restart;
  logic        bit_end;
  logic [15:0] count_inc;
`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0]  csum_reg, csum_next;
  logic        csum_sent_reg, csum_sent_next;
  logic        gap_reg, gap_next;
`endif

  assign trigger   = finished & ~finished_reg;
  assign count_inc = count_reg + 16'd1;
  assign mem_addr  = BASE_ADDR + count_reg;  // 16-bit modulo by width

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .bit_end(bit_end)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      shift_reg     <= '0;
      bit_reg       <= '0;
      finished_reg  <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_reg      <= '0;
      csum_sent_reg <= 1'b0;
      gap_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      shift_reg     <= shift_next;
      bit_reg       <= bit_next;
      finished_reg  <= finished;
`ifdef RESULT_TX_CHECKSUM_EN
      csum_reg      <= csum_next;
      csum_sent_reg <= csum_sent_next;
      gap_reg       <= gap_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
`ifdef RESULT_TX_CHECKSUM_EN
    csum_next      = csum_reg;
    csum_sent_next = csum_sent_reg;
    gap_next       = gap_reg;
`endif
    tx      = 1'b1;
    mem_rd  = 1'b0;
    restart = 1'b1;  // timer parked at zero unless a bit is on the line
    busy    = (state_reg != IDLE) && (state_reg != DONE);
    done    = (state_reg == DONE);

    case (state_reg)
      IDLE: begin
        if (trigger) begin
          state_next = FETCH;
          count_next = '0;
`ifdef RESULT_TX_CHECKSUM_EN
          csum_next      = '0;
          csum_sent_next = 1'b0;
          gap_next       = 1'b0;
`endif
        end
      end
      FETCH: begin
        mem_rd     = 1'b1;
        state_next = LATCH;
      end
      LATCH: begin
        shift_next = mem_data;
`ifdef RESULT_TX_CHECKSUM_EN
        csum_next = csum_reg ^ mem_data;
`endif
        state_next = START;
      end
      START: begin
        restart = 1'b0;
        tx      = 1'b0;
        if (bit_end) begin
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        restart = 1'b0;
        tx      = shift_reg[0];
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == 3'(DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      STOP: begin
        restart = 1'b0;
        if (bit_end) begin
`ifdef RESULT_TX_CHECKSUM_EN
          if (csum_sent_reg) begin
            state_next = DONE;
          end else begin
            count_next = count_inc;
            state_next = (count_inc == LEN) ? CSUM : FETCH;
          end
`else
          count_next = count_inc;
          state_next = (count_inc == LEN) ? DONE : FETCH;
`endif
        end
      end
`ifdef RESULT_TX_CHECKSUM_EN
      // Two idle-high cycles, matching the FETCH/LATCH gap of data bytes,
      // then the checksum goes out through the normal START/DATA/STOP path.
      CSUM: begin
        gap_next = 1'b1;
        if (gap_reg) begin
          gap_next       = 1'b0;
          shift_next     = csum_reg;
          csum_sent_next = 1'b1;
          state_next     = START;
        end
      end
`endif
      DONE: begin
        if (!finished) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx
// Directed bench for result_uart_tx: CLKS_PER_BIT=4, BASE_ADDR=0x0010, LEN=3
// with A5/3C/FF in memory, plus a second instance at BASE_ADDR=0xFFFF, LEN=2
// for address wrap. Define RESULT_TX_CHECKSUM_EN to expect the XOR frame.
module tb_result_uart_tx;

  localparam int CPB = 4;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int DONE_OFS = 127 + 42;
`else
  localparam int DONE_OFS = 127;
`endif

  logic        clock;
  logic        reset;
  logic        finished, finished_w;
  logic [15:0] mem_addr, mem_addr_w;
  logic        mem_rd, mem_rd_w;
  logic [7:0]  mem_data, mem_data_w;
  logic        tx, tx_w;
  logic        busy, busy_w;
  logic        done, done_w;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [15:0] rd_w_q[$];

  result_uart_tx #(
    .CLKS_PER_BIT(CPB), .BASE_ADDR(16'h0010), .LEN(16'd3)
  ) dut (
    .clock(clock), .reset(reset), .finished(finished),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .tx(tx), .busy(busy), .done(done)
  );

  result_uart_tx #(
    .CLKS_PER_BIT(CPB), .BASE_ADDR(16'hFFFF), .LEN(16'd2)
  ) dut_w (
    .clock(clock), .reset(reset), .finished(finished_w),
    .mem_addr(mem_addr_w), .mem_rd(mem_rd_w), .mem_data(mem_data_w),
    .tx(tx_w), .busy(busy_w), .done(done_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    case (a)
      16'h0010: return 8'hA5;
      16'h0011: return 8'h3C;
      16'h0012: return 8'hFF;
      16'hFFFF: return 8'h5A;
      16'h0000: return 8'hC3;
      default:  return 8'h00;
    endcase
  endfunction

  // Synchronous memories and read-strobe logging; cyc names the cycle that
  // ends at this edge.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_rd) begin
      mem_data <= mem_model(mem_addr);
      rd_addr_q.push_back(mem_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (mem_rd_w) begin
      mem_data_w <= mem_model(mem_addr_w);
      rd_w_q.push_back(mem_addr_w);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tx_low(input string tag, output bit ok);
    int w;
    w = 0;
    while (tx !== 1'b0 && w < 400) begin
      @(negedge clock);
      w++;
    end
    ok = (tx === 1'b0);
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Entered at a negedge while the line is idle/stop; samples mid-bit.
  task automatic frame_rx(input string tag, input logic [7:0] exp, output int start_cyc);
    logic [7:0] b;
    bit ok;
    b = '0;
    wait_tx_low(tag, ok);
    start_cyc = cyc;
    if (ok) begin
      repeat (CPB / 2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clock);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clock);
      check({tag, "_stop"}, 32'(tx), 32'd1);
      check(tag, 32'(b), 32'(exp));
      $display("frame %s: byte %02h start cycle %0d", tag, b, start_cyc);
    end
  endtask

  task automatic run_dump(input string tag);
    int c0, n0, s0, s, w;
    n0 = rd_addr_q.size();
    c0 = cyc;
    finished = 1'b1;
    frame_rx({tag, "_b0"}, 8'hA5, s0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    frame_rx({tag, "_b1"}, 8'h3C, s);
    frame_rx({tag, "_b2"}, 8'hFF, s);
`ifdef RESULT_TX_CHECKSUM_EN
    frame_rx({tag, "_csum"}, 8'h66, s);
`endif
    w = 0;
    while (done !== 1'b1 && w < 200) begin
      @(negedge clock);
      w++;
    end
    check({tag, "_done_cyc"}, 32'(cyc - c0), 32'(DONE_OFS));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_start_cyc"}, 32'(s0 - c0), 32'd3);
    check({tag, "_nrd"}, 32'(rd_addr_q.size() - n0), 32'd3);
    if (rd_addr_q.size() >= n0 + 3) begin
      check({tag, "_rd_cyc"}, 32'(rd_cyc_q[n0] - c0), 32'd1);
      for (int i = 0; i < 3; i++) begin
        check({tag, "_addr"}, 32'(rd_addr_q[n0 + i]), 32'(16'h0010 + i));
      end
    end
    $display("dump %s: done after %0d cycles", tag, cyc - c0);
  endtask

  initial begin
    int n, s, w;
    bit ok;
    reset = 1'b1;
    finished = 1'b0;
    finished_w = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd", 32'(mem_rd), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h0010);
    check("rst_addr_w", 32'(mem_addr_w), 32'hFFFF);
    reset = 1'b0;

    repeat (50) @(negedge clock);
    check("idle_nrd", 32'(rd_addr_q.size()), 32'd0);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    run_dump("d1");

    // Level held high must not retrigger.
    n = rd_addr_q.size();
    repeat (20) @(negedge clock);
    check("hold_done", 32'(done), 32'd1);
    check("hold_nrd", 32'(rd_addr_q.size() - n), 32'd0);
    finished = 1'b0;
    @(negedge clock);
    check("drop_done", 32'(done), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clock);
    check("drop_nrd", 32'(rd_addr_q.size() - n), 32'd0);

    run_dump("d2");

    // Reset during bit 4 of the second byte.
    finished = 1'b0;
    repeat (2) @(negedge clock);
    finished = 1'b1;
    frame_rx("r_b0", 8'hA5, s);
    wait_tx_low("r_b1", ok);
    repeat (5 * CPB + 1) @(negedge clock);
    check("r_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    finished = 1'b0;
    n = rd_addr_q.size();
    @(negedge clock);
    check("r_tx", 32'(tx), 32'd1);
    check("r_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("r_nrd", 32'(rd_addr_q.size() - n), 32'd0);
    check("r_tx_idle", 32'(tx), 32'd1);

    run_dump("d3");

    // Address wrap instance.
    finished_w = 1'b1;
    w = 0;
    while (done_w !== 1'b1 && w < 300) begin
      @(negedge clock);
      w++;
    end
    check("w_done", 32'(done_w), 32'd1);
    check("w_nrd", 32'(rd_w_q.size()), 32'd2);
    if (rd_w_q.size() >= 2) begin
      check("w_addr0", 32'(rd_w_q[0]), 32'hFFFF);
      check("w_addr1", 32'(rd_w_q[1]), 32'h0000);
    end
    $display("wrap dump: %0d reads", rd_w_q.size());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
